// File: rtl/rat_recovery_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rat_recovery_ctrl: flush recovery, RAT copy and free-list bitmap rebuild  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rat_recovery_ctrl #(
    parameter int ARCH_REGS    = 32,
    parameter int PREG_W       = 7,
    parameter int SCAN_PER_CYC = 4
) (
    input  logic                          Clk,
    input  logic                          Rest,
    input  logic                          FlushReq,
    input  logic                          RetireBusy,
    input  logic [ARCH_REGS*PREG_W-1:0]   ArchMap,
    output logic                          ArchSStop,
    output logic                          ReMapping,
    output logic                          RecoverBusy,
    output logic                          FreeListLoad,
    output logic [(1<<PREG_W)-1:0]        FreeBitmap,
    output logic                          AliasErr,
    output logic                          RecoverDone
);

    localparam int NPREG       = 1 << PREG_W;
    localparam int MAP_W       = ARCH_REGS * PREG_W;
    localparam int IDX_W       = $clog2(MAP_W);
    localparam int SCAN_CYCLES = ARCH_REGS / SCAN_PER_CYC;
    localparam logic [2:0] SCAN_LAST = 3'(SCAN_CYCLES - 1);
    // Reset identity map: r0..r31 own p0..p31, everything above is free.
    localparam logic [NPREG-1:0] BITMAP_RST = {{(NPREG-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAITRET = 3'd1,
        COPY    = 3'd2,
        SCAN    = 3'd3,
        LOAD    = 3'd4
    } state_t;

    state_t             state;
    logic [2:0]         scan_cnt;
    logic               alias_flag;
    logic [NPREG-1:0]   scan_bitmap;
    logic               scan_alias;
    logic [PREG_W-1:0]  preg;
    logic [IDX_W-1:0]   base;

    // Lower k clears first, so a duplicate within one cycle is caught too.
    always_comb begin
        scan_bitmap = FreeBitmap;
        scan_alias  = alias_flag;
        preg        = '0;
        base        = '0;
        for (int k = 0; k < SCAN_PER_CYC; k++) begin
            base = IDX_W'((int'(scan_cnt) * SCAN_PER_CYC + k) * PREG_W);
            preg = ArchMap[base +: PREG_W];
            if (!scan_bitmap[preg]) begin
                scan_alias = 1'b1;
            end
            scan_bitmap[preg] = 1'b0;
        end
    end

    // Outputs are registered alongside the state, so they follow it exactly.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state        <= IDLE;
            scan_cnt     <= '0;
            alias_flag   <= 1'b0;
            FreeBitmap   <= BITMAP_RST;
            ArchSStop    <= 1'b0;
            ReMapping    <= 1'b0;
            RecoverBusy  <= 1'b0;
            FreeListLoad <= 1'b0;
            AliasErr     <= 1'b0;
            RecoverDone  <= 1'b0;
        end else begin
            FreeListLoad <= 1'b0;
            AliasErr     <= 1'b0;
            RecoverDone  <= 1'b0;
            case (state)
                IDLE: begin
                    if (FlushReq) begin
                        state       <= WAITRET;
                        RecoverBusy <= 1'b1;
                    end
                end
                WAITRET: begin
                    if (!RetireBusy) begin
                        state     <= COPY;
                        ArchSStop <= 1'b1;
                        ReMapping <= 1'b1;
                    end
                end
                COPY: begin
                    state      <= SCAN;
                    FreeBitmap <= '1;
                    alias_flag <= 1'b0;
                    scan_cnt   <= '0;
                end
                SCAN: begin
                    FreeBitmap <= scan_bitmap;
                    alias_flag <= scan_alias;
                    scan_cnt   <= scan_cnt + 3'd1;
                    if (scan_cnt == SCAN_LAST) begin
                        state        <= LOAD;
                        ReMapping    <= 1'b0;
                        FreeListLoad <= 1'b1;
                        RecoverDone  <= 1'b1;
                        AliasErr     <= scan_alias;
                    end
                end
                LOAD: begin
                    state       <= IDLE;
                    ArchSStop   <= 1'b0;
                    RecoverBusy <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    ArchSStop   <= 1'b0;
                    ReMapping   <= 1'b0;
                    RecoverBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rat_recovery_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rat_recovery_ctrl: randomized bench against a mapping-level model      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rat_recovery_ctrl;

    logic         Clk = 1'b0;
    logic         Rest;
    logic         FlushReq;
    logic         RetireBusy;
    logic [223:0] ArchMap;
    logic         ArchSStop;
    logic         ReMapping;
    logic         RecoverBusy;
    logic         FreeListLoad;
    logic [127:0] FreeBitmap;
    logic         AliasErr;
    logic         RecoverDone;

    rat_recovery_ctrl dut (
        .Clk          (Clk),
        .Rest         (Rest),
        .FlushReq     (FlushReq),
        .RetireBusy   (RetireBusy),
        .ArchMap      (ArchMap),
        .ArchSStop    (ArchSStop),
        .ReMapping    (ReMapping),
        .RecoverBusy  (RecoverBusy),
        .FreeListLoad (FreeListLoad),
        .FreeBitmap   (FreeBitmap),
        .AliasErr     (AliasErr),
        .RecoverDone  (RecoverDone)
    );

    always #5 Clk = ~Clk;

    localparam logic [127:0] BITMAP_RST = {{96{1'b1}}, {32{1'b0}}};

    int           checks   = 0;
    int           failures = 0;
    int unsigned  amap [32];
    logic [127:0] exp_bitmap;
    bit           exp_alias;

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ctrl_vec();
        return 128'({RecoverBusy, ArchSStop, ReMapping, FreeListLoad, RecoverDone, AliasErr});
    endfunction

    // Expected controls from the published timeline, shifted by b busy cycles.
    function automatic logic [127:0] exp_ctrl(input int c, input int b);
        bit busy, stop, remap, load, alias_o;
        busy    = (c >= 1) && (c <= 11 + b);
        stop    = (c >= 2 + b) && (c <= 11 + b);
        remap   = (c >= 2 + b) && (c <= 10 + b);
        load    = (c == 11 + b);
        alias_o = load && exp_alias;
        return 128'({busy, stop, remap, load, load, alias_o});
    endfunction

    // Free = not named by any architectural register; alias = some preg named twice.
    task automatic apply_map();
        logic [6:0] p;
        exp_bitmap = '1;
        exp_alias  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            p = 7'(amap[i]);
            ArchMap[i*7 +: 7] = p;
            exp_bitmap[p] = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (amap[j] == amap[i]) exp_alias = 1'b1;
            end
        end
    endtask

    task automatic identity_map();
        for (int i = 0; i < 32; i++) amap[i] = i;
    endtask

    task automatic random_map(input bit allow_dup);
        int unsigned pool [128];
        int unsigned tmp;
        int          r;
        for (int i = 0; i < 128; i++) pool[i] = i;
        for (int i = 127; i > 0; i--) begin
            r = $urandom_range(0, i);
            tmp = pool[i]; pool[i] = pool[r]; pool[r] = tmp;
        end
        for (int i = 0; i < 32; i++) amap[i] = allow_dup ? $urandom_range(0, 127) : pool[i];
    endtask

    // Caller is at a negedge in IDLE; flush is raised in cycle 0.
    task automatic run_recovery(input int b, input int reflush);
        FlushReq   = 1'b1;
        RetireBusy = 1'($urandom_range(0, 1));
        for (int c = 1; c <= 12 + b; c++) begin
            @(negedge Clk);
            check_value($sformatf("ctrl_c%0d_b%0d", c, b), ctrl_vec(), exp_ctrl(c, b));
            if (c >= 11 + b) check_value($sformatf("bitmap_c%0d", c), FreeBitmap, exp_bitmap);
            FlushReq   = (c == reflush);
            RetireBusy = (c <= b);
        end
    endtask

    task automatic reset_mid(input int at);
        FlushReq   = 1'b1;
        RetireBusy = 1'b0;
        for (int c = 1; c <= at; c++) begin
            @(negedge Clk);
            FlushReq = 1'b0;
        end
        #1 Rest = 1'b0;
        #1;
        check_value("async_rst_ctrl", ctrl_vec(), 128'd0);
        check_value("async_rst_bitmap", FreeBitmap, BITMAP_RST);
        @(negedge Clk);
        check_value("rst_hold_ctrl", ctrl_vec(), 128'd0);
        Rest = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        int b;
        int reflush;
        Rest       = 1'b0;
        FlushReq   = 1'b0;
        RetireBusy = 1'b0;
        ArchMap    = '0;
        repeat (3) @(negedge Clk);
        check_value("reset_ctrl", ctrl_vec(), 128'd0);
        check_value("reset_bitmap", FreeBitmap, BITMAP_RST);
        Rest = 1'b1;
        @(negedge Clk);

        identity_map(); apply_map();
        run_recovery(0, 0);

        run_recovery(3, 0);

        identity_map(); amap[5] = 100; amap[31] = 127; apply_map();
        run_recovery(0, 0);

        identity_map(); amap[3] = 40; amap[9] = 40; apply_map();
        run_recovery(0, 0);

        identity_map(); apply_map();
        run_recovery(0, 6);
        run_recovery(1, 0);

        reset_mid(5);
        check_value("post_rst_bitmap", FreeBitmap, BITMAP_RST);
        random_map(1'b0); apply_map();
        run_recovery(0, 0);

        for (int n = 0; n < 24; n++) begin
            random_map(n[0]); apply_map();
            b = $urandom_range(0, 4);
            reflush = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 11 + b) : 0;
            run_recovery(b, reflush);
            repeat ($urandom_range(0, 2)) begin
                @(negedge Clk);
                check_value("idle_gap", ctrl_vec(), 128'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rat_recovery_ctrl.md
# rat_recovery_ctrl

Flush-recovery sequencer for the rename stage. On a ROB flush it waits for in-flight retirement to finish, freezes the architectural RAT (`ArchSStop`), and drives `ReMapping` so the speculative RAT reloads from architectural state. It then scans the 32 architectural mappings, four per cycle, to rebuild the physical-register free-list bitmap, and loads that bitmap into the free list. It sits between the ROB/retire logic, the architectural RAT, the speculative RAT and the free list.

## Interface
Parameters:
- `ARCH_REGS`, 32, number of architectural registers; fixed, the scan counter is sized for 32.
- `PREG_W`, 7, physical register index width; the physical register file has 2^PREG_W = 128 entries.
- `SCAN_PER_CYC`, 4, mappings examined per SCAN cycle.

Ports (clock and reset first):
- `Clk`, in, 1, single clock; all state updates on the rising edge.
- `Rest`, in, 1, reset; asynchronous, active-low.
- `FlushReq`, in, 1, single-cycle flush pulse from the ROB (mispredict or exception).
- `RetireBusy`, in, 1, high while retire is writing the architectural RAT this cycle.
- `ArchMap`, in, ARCH_REGS*PREG_W (224), flattened architectural mappings; entry i is `[i*7+6:i*7]`. Valid only while `ReMapping`=1.
- `ArchSStop`, out, 1, freezes the architectural RAT.
- `ReMapping`, out, 1, architectural RAT drives its mappings; the speculative RAT copies them.
- `RecoverBusy`, out, 1, stalls fetch, decode and rename.
- `FreeListLoad`, out, 1, one-cycle pulse; the free list overwrites itself with `FreeBitmap`.
- `FreeBitmap`, out, 128, bit p = 1 means physical register p is free.
- `AliasErr`, out, 1, one-cycle pulse with `FreeListLoad` if any physical register was mapped twice.
- `RecoverDone`, out, 1, one-cycle pulse with `FreeListLoad`.

## Operation
- FSM states: IDLE, WAITRET, COPY, SCAN, LOAD. Encoding is registered; all control outputs are decoded from the current state (Moore).
- IDLE:
  - `FlushReq`=1 → WAITRET.
  - Otherwise stay in IDLE.
- WAITRET:
  - `RetireBusy`=1 → stay in WAITRET. `ArchSStop`=0 so the last retirements still land.
  - `RetireBusy`=0 → COPY.
- COPY (1 cycle):
  - `ArchSStop`=1, `ReMapping`=1.
  - Set `FreeBitmap` to all ones, clear the alias flag, set `ScanCnt`=0.
  - Next state: SCAN.
- SCAN (8 cycles):
  - `ArchSStop`=1, `ReMapping`=1.
  - Each cycle, for k = 0..3, take entry e = `ScanCnt`*4+k and clear bit `ArchMap[e]` in the bitmap.
  - If that bit was already 0 (entering this cycle, or set earlier in the same cycle by a lower k), set the alias flag.
  - `ScanCnt` is 3 bits. At `ScanCnt`=7 the state goes to LOAD and the counter wraps to 0.
- LOAD (1 cycle):
  - `ArchSStop`=1, `FreeListLoad`=1, `RecoverDone`=1.
  - `AliasErr` = alias flag.
  - Next state: IDLE.
- `RecoverBusy` = 1 in every state except IDLE.
- `FlushReq` outside IDLE is ignored. The recovery in progress already restores full architectural state, so a second flush needs no action.
- `FreeBitmap` holds its value after LOAD until the next COPY.

## Timing
- Reset (async, `Rest`=0):
  - state = IDLE, `ScanCnt`=0.
  - `FreeBitmap` = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000, matching the reset identity map of p0..p31.
  - All 1-bit outputs = 0, alias flag = 0.
- Reset mid-recovery aborts immediately to the reset values above.
- Cycle timeline with `FlushReq` at cycle 0 and `RetireBusy`=0 throughout:

  | State | Cycle(s) |
  |---|---|
  | WAITRET | 1 |
  | COPY | 2 |
  | SCAN | 3–10 |
  | LOAD | 11 |
  | IDLE | 12 |

- Resulting output windows:
  - `RecoverBusy`: cycles 1–11.
  - `ArchSStop`: cycles 2–11.
  - `ReMapping`: cycles 2–10.
  - `FreeListLoad`, `RecoverDone`: cycle 11.
- Every cycle of `RetireBusy`=1 in WAITRET adds one cycle to the total latency.
- A new `FlushReq` in cycle 12 starts a new recovery; it is accepted.

## Test plan
- Reset, then a flush with the identity map (entry i = i) and `RetireBusy`=0 → `FreeListLoad` at cycle 11 with `FreeBitmap` = ones above bit 31 and zeros in bits 31..0; `AliasErr`=0.
- `RetireBusy` held high for 3 cycles after `FlushReq` → state stays in WAITRET with `ArchSStop`=0; `ReMapping` first rises at cycle 5; `RecoverDone` at cycle 14.
- Map r5→p100 and r31→p127, all other entries identity → bits 5 and 31 set, bits 100 and 127 cleared.
- Map r3→p40 and r9→p40 → `AliasErr`=1 together with `FreeListLoad`; bit 40 = 0.
- `FlushReq` pulsed again at cycle 6 → ignored; exactly one `RecoverDone`, at cycle 11.
- `Rest` asserted at cycle 5 → all outputs return to reset values asynchronously; a flush after reset release completes normally.
